fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller that drives the program counter's PI, PL and AD inputs and consumes its 8-bit address.
- Fetches each instruction from memory at the current PC address using a req/ready handshake, then presents it downstream with a valid/ready handshake.
- Decodes branch classes and issues exactly one PC update pulse per instruction: PI to increment, or PL to add a signed 6-bit offset.

Parameters:
ADDR_W, 8, PC/memory address width
DATA_W, 8, instruction width
OFF_W, 6, branch offset width (bit OFF_W-1 is the sign)
TIMEOUT_CYCLES, 15, maximum mem_ready wait cycles (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
pc_addr  in  ADDR_W  current PC value (program counter add_out)
mem_addr  out  ADDR_W  fetch address to instruction memory
mem_req  out  1  fetch request, held until mem_ready
mem_ready  in  1  memory has mem_rdata valid this cycle
mem_rdata  in  DATA_W  instruction word
cond_flag  in  1  branch condition from datapath (e.g. zero flag), sampled in DECODE
instr_out  out  DATA_W  latched instruction
instr_valid  out  1  instr_out valid
instr_ready  in  1  downstream accepts instr_out
PI  out  1  PC increment pulse
PL  out  1  PC relative-load pulse
AD  out  OFF_W  branch offset to PC, instr[5:0]
halted  out  1  HALT executed
fetch_err  out  1  fetch timeout (FETCH_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state=FETCH.
  - mem_req=0, instr_valid=0, PI=0, PL=0, AD=0, instr_out=0, halted=0, fetch_err=0.
  - Outputs go to these values immediately, not at a clock edge.
- mem_addr=pc_addr, combinational pass-through.
- Instruction classes on instr[7:6]:
  - 2'b00 / 2'b01: normal.
  - 2'b10: unconditional relative branch.
  - 2'b11: conditional relative branch, taken iff cond_flag=1.
  - instr = 8'h7F is HALT.
- States:
  - FETCH: mem_req=1. On mem_ready=1, latch mem_rdata into instr_out and go to DECODE. Otherwise stay.
  - DECODE: instr_valid=1. On instr_ready=1, go to UPDATE, or to HALT if instr = 8'h7F. cond_flag is sampled on this accept edge.
  - UPDATE: exactly one cycle.
    - Normal, or not-taken conditional: PI=1, PL=0.
    - Taken branch: PL=1, PI=0, AD=instr[5:0].
    - Then go to FETCH.
  - HALT: halted=1, no PI/PL, mem_req=0. Stays until reset.
- PI and PL are registered, never asserted together, and high for exactly one cycle per instruction.
- AD is held stable from DECODE through UPDATE; it equals instr[5:0] whenever PL=1.
- The PC updates on the UPDATE edge. The next FETCH therefore sees the new pc_addr.
- Minimum cycles per instruction: 3 (FETCH with immediate ready, DECODE with immediate accept, UPDATE).
- Branch offset:
  - Sign extension is done by the PC; this block passes the raw 6 bits.
  - Offset 6'b000000 with PL re-fetches the same address. This is legal (self-loop).
- Address wrap-around (8'hFF+1 → 8'h00) is PC behaviour and needs no special handling here.
- mem_ready while not in FETCH is ignored.
- instr_ready while not in DECODE is ignored.
- instr_out and instr_valid stay stable while instr_valid=1 and instr_ready=0.
- Reset mid-fetch or mid-decode aborts immediately. No PI/PL pulse is emitted for the aborted instruction.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to FETCH and increments each FETCH cycle with mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES, go to ERR: fetch_err=1, mem_req=0, no PI/PL. ERR is sticky until reset.
- Undefined: no counter, no ERR state, fetch_err tied 0, FETCH waits indefinitely.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W, DATA_W, OFF_W
  - opcode class constants CLS_BR=2'b10, CLS_BRC=2'b11
  - HALT_OP=8'h7F
  - state enum {FETCH, DECODE, UPDATE, HALT, ERR}
- One natural sub-module: instr_classify, purely combinational.
  - Inputs: instr, cond_flag.
  - Outputs: is_halt, take_branch.
- The FSM and output registers stay in fetch_sequencer.

Test Plan:
- Reset then memory returns 8'h05 with zero wait, instr_ready=1 → instr_valid 1 cycle after mem_ready; PI=1 for one cycle; PL never asserted; the next fetch sees pc_addr+1.
- Fetch 8'hBE (class 10, offset 6'h3E = -2) → PL=1 one cycle, AD=6'h3E, PI=0; PC driven from 8'h10 to 8'h0E.
- Fetch 8'hC4 with cond_flag=0, then 8'hC4 with cond_flag=1 → first gives PI=1; second gives PL=1 with AD=6'h04.
- Hold instr_ready=0 for 5 cycles in DECODE → instr_out and instr_valid stable; no PI/PL until the accept cycle; mem_req=0 throughout.
- Fetch 8'h7F → halted=1 after accept, mem_req stays 0, no PI/PL for 20 cycles; rst_n pulse clears halted.
- FETCH_TIMEOUT_EN with mem_ready held 0 → fetch_err=1 after 15 wait cycles; mem_ready=1 at wait 14 → normal completion, fetch_err=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path widths, opcode class constants and sequencer state encoding.
// TIMEOUT_CYCLES is only consumed when FETCH_TIMEOUT_EN is defined.
package cpu_pkg;

   localparam int unsigned ADDR_W         = 8;
   localparam int unsigned DATA_W         = 8;
   localparam int unsigned OFF_W          = 6;
   localparam int unsigned TIMEOUT_CYCLES = 15;

   localparam logic [1:0]        CLS_BR  = 2'b10;
   localparam logic [1:0]        CLS_BRC = 2'b11;
   localparam logic [DATA_W-1:0] HALT_OP = 8'h7F;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      UPDATE,
      HALT,
      ERR
   } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory request/response and downstream instruction handshake.
// master = fetch_sequencer side, slave = memory/consumer side.
interface fetch_sequencer_if;
   import cpu_pkg::*;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_req;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] instr_out;
   logic              instr_valid;
   logic              instr_ready;

   modport master (
      output mem_addr, mem_req, instr_out, instr_valid,
      input  mem_ready, mem_rdata, instr_ready
   );

   modport slave (
      input  mem_addr, mem_req, instr_out, instr_valid,
      output mem_ready, mem_rdata, instr_ready
   );

endinterface

// File: rtl/instr_classify.sv
// Combinational branch/halt classification of a fetched instruction word.
module instr_classify
   import cpu_pkg::*;
(
   input  logic [DATA_W-1:0] instr,
   input  logic              cond_flag,
   output logic              is_halt,
   output logic              take_branch
);

   logic [1:0] cls;

   assign cls         = instr[DATA_W-1 -: 2];
   assign is_halt     = (instr == HALT_OP);
   assign take_branch = (cls == CLS_BR) || ((cls == CLS_BRC) && cond_flag);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: FETCH -> DECODE -> UPDATE, one PI or PL pulse per instruction.
// Optional fetch timeout with sticky ERR state when FETCH_TIMEOUT_EN is defined.
module fetch_sequencer
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDR_W-1:0]    pc_addr,
   input  logic                 cond_flag,
   fetch_sequencer_if.master    bus,
   output logic                 PI,
   output logic                 PL,
   output logic [OFF_W-1:0]     AD,
   output logic                 halted,
   output logic                 fetch_err
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              mem_req_q, instr_valid_q, halted_q;
   logic              pi_q, pi_d, pl_q, pl_d;
   logic              is_halt, take_branch;

   instr_classify u_classify (
      .instr       (instr_q),
      .cond_flag   (cond_flag),
      .is_halt     (is_halt),
      .take_branch (take_branch)
   );

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic             fetch_wait;
   logic             fetch_err_q;

   assign fetch_wait = (state_q == FETCH) && mem_req_q && !bus.mem_ready;

   // Held at zero outside FETCH so every FETCH entry starts a fresh count.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_q != FETCH) begin
         wait_cnt_d = '0;
      end else if (fetch_wait) begin
         wait_cnt_d = wait_cnt_q + WaitW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q  <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         fetch_err_q <= (state_d == ERR);
      end
   end

   assign fetch_err = fetch_err_q;
`else
   assign fetch_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      pi_d    = 1'b0;
      pl_d    = 1'b0;
      case (state_q)
         FETCH: begin
            // mem_req is registered, so the first post-reset cycle issues no request.
            if (mem_req_q && bus.mem_ready) begin
               instr_d = bus.mem_rdata;
               state_d = DECODE;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (fetch_wait && (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1))) begin
               state_d = ERR;
            end
`endif
         end
         DECODE: begin
            if (bus.instr_ready) begin
               if (is_halt) begin
                  state_d = HALT;
               end else begin
                  state_d = UPDATE;
                  pi_d    = !take_branch;
                  pl_d    = take_branch;
               end
            end
         end
         UPDATE:  state_d = FETCH;
         HALT:    state_d = HALT;
         ERR:     state_d = ERR;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         instr_q       <= '0;
         mem_req_q     <= 1'b0;
         instr_valid_q <= 1'b0;
         pi_q          <= 1'b0;
         pl_q          <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         mem_req_q     <= (state_d == FETCH);
         instr_valid_q <= (state_d == DECODE);
         pi_q          <= pi_d;
         pl_q          <= pl_d;
         halted_q      <= (state_d == HALT);
      end
   end

   assign bus.mem_addr    = pc_addr;
   assign bus.mem_req     = mem_req_q;
   assign bus.instr_out   = instr_q;
   assign bus.instr_valid = instr_valid_q;
   assign PI              = pi_q;
   assign PL              = pl_q;
   assign AD              = instr_q[OFF_W-1:0];
   assign halted          = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a PC model and an instruction scoreboard.
// Exercises the FETCH_TIMEOUT_EN path when that macro is defined.
module tb_fetch_sequencer;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] pc;
   logic [7:0] pc_reset_val;
   logic       cond_flag;
   logic       PI, PL, halted, fetch_err;
   logic [5:0] AD;

   fetch_sequencer_if bus ();

   fetch_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pc_addr   (pc),
      .cond_flag (cond_flag),
      .bus       (bus),
      .PI        (PI),
      .PL        (PL),
      .AD        (AD),
      .halted    (halted),
      .fetch_err (fetch_err)
   );

   always #5 clk = ~clk;

   // Program counter model: increments on PI, adds sign-extended AD on PL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  pc <= pc_reset_val;
      else if (PI) pc <= pc + 8'd1;
      else if (PL) pc <= pc + {{2{AD[5]}}, AD};
   end

   typedef struct packed {
      logic [7:0] instr;
      logic       halt;
      logic       take;
   } exp_t;

   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_pc;

   task automatic reset_dut(input logic [7:0] start);
      pc_reset_val    = start;
      rst_n           = 1'b0;
      bus.mem_ready   = 1'b0;
      bus.mem_rdata   = 8'h00;
      bus.instr_ready = 1'b0;
      cond_flag       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      exp_pc = start;
      sb_q.delete();
   endtask

   task automatic run_instr(input logic [7:0] ins, input logic cond, input int mem_wait,
                            input int hold);
      exp_t e;
      bit   got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = (bus.mem_req === 1'b1);
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL req_timeout mem_req never rose for instr %h", ins);
         return;
      end
      checks++;
      if (bus.mem_addr !== exp_pc) begin
         errors++;
         $display("FAIL fetch_addr got %h want %h", bus.mem_addr, exp_pc);
      end
      for (int i = 0; i < mem_wait; i++) begin
         bus.mem_ready = 1'b0;
         bus.mem_rdata = ~ins;
         @(negedge clk);
         checks++;
         if (bus.mem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_req req %b valid %b want 1 0", bus.mem_req, bus.instr_valid);
         end
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = ins;
      cond_flag     = cond;
      e.instr = ins;
      e.halt  = (ins == 8'h7F);
      e.take  = (ins[7:6] == 2'b10) || ((ins[7:6] == 2'b11) && cond);
      sb_q.push_back(e);
      @(negedge clk);
      e = sb_q.pop_front();
      for (int k = 0; k <= hold; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (bus.instr_valid !== 1'b1 || bus.instr_out !== e.instr) begin
            errors++;
            $display("FAIL decode_out valid %b instr %h want 1 %h",
                     bus.instr_valid, bus.instr_out, e.instr);
         end
         checks++;
         if (PI !== 1'b0 || PL !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL decode_quiet PI %b PL %b req %b want 0 0 0", PI, PL, bus.mem_req);
         end
         // Spurious mem_ready with garbage data during DECODE must be ignored.
         bus.mem_ready   = (k != hold);
         bus.mem_rdata   = ~ins;
         bus.instr_ready = (k == hold);
      end
      @(negedge clk);
      bus.instr_ready = 1'b0;
      bus.mem_ready   = 1'b0;
      if (e.halt) begin
         checks++;
         if (halted !== 1'b1 || PI !== 1'b0 || PL !== 1'b0) begin
            errors++;
            $display("FAIL halt_entry halted %b PI %b PL %b want 1 0 0", halted, PI, PL);
         end
      end else begin
         checks++;
         if (PI !== !e.take || PL !== e.take) begin
            errors++;
            $display("FAIL update_pulse PI %b PL %b want %b %b", PI, PL, !e.take, e.take);
         end
         if (e.take) begin
            checks++;
            if (AD !== e.instr[5:0]) begin
               errors++;
               $display("FAIL update_ad got %h want %h", AD, e.instr[5:0]);
            end
            exp_pc = exp_pc + {{2{e.instr[5]}}, e.instr[5:0]};
         end else begin
            exp_pc = exp_pc + 8'd1;
         end
         @(negedge clk);
         checks++;
         if (PI !== 1'b0 || PL !== 1'b0 || bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL post_update PI %b PL %b req %b want 0 0 1", PI, PL, bus.mem_req);
         end
      end
   endtask

   task automatic test_reset();
      pc_reset_val    = 8'h5A;
      rst_n           = 1'b1;
      bus.mem_ready   = 1'b0;
      bus.mem_rdata   = 8'h00;
      bus.instr_ready = 1'b0;
      cond_flag       = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.mem_req, bus.instr_valid, PI, PL, halted, fetch_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl req/valid/PI/PL/halt/err %b want 000000",
                  {bus.mem_req, bus.instr_valid, PI, PL, halted, fetch_err});
      end
      checks++;
      if (AD !== 6'h00 || bus.instr_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_data AD %h instr %h want 00 00", AD, bus.instr_out);
      end
      checks++;
      if (bus.mem_addr !== 8'h5A) begin
         errors++;
         $display("FAIL addr_pass got %h want 5a", bus.mem_addr);
      end
   endtask

   task automatic test_normal();
      reset_dut(8'h00);
      run_instr(8'h05, 1'b0, 0, 0);
      run_instr(8'h3A, 1'b0, 2, 0);
      run_instr(8'h41, 1'b1, 0, 1);
      run_instr(8'h00, 1'b0, 0, 0);
   endtask

   task automatic test_branch();
      reset_dut(8'h10);
      run_instr(8'hBE, 1'b0, 0, 0);
      run_instr(8'h01, 1'b0, 0, 0);
   endtask

   task automatic test_cond();
      run_instr(8'hC4, 1'b0, 0, 0);
      run_instr(8'hC4, 1'b1, 1, 0);
      run_instr(8'h80, 1'b0, 0, 0);
      run_instr(8'hFF, 1'b1, 0, 0);
      run_instr(8'hFF, 1'b0, 0, 0);
      run_instr(8'h02, 1'b0, 0, 0);
   endtask

   task automatic test_wrap();
      reset_dut(8'hFF);
      run_instr(8'h11, 1'b0, 0, 0);
      run_instr(8'h22, 1'b0, 0, 0);
   endtask

   task automatic test_hold();
      run_instr(8'h12, 1'b0, 0, 5);
      run_instr(8'h9F, 1'b0, 0, 3);
      run_instr(8'h13, 1'b0, 0, 0);
   endtask

   task automatic test_halt();
      run_instr(8'h7F, 1'b0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         bus.mem_ready   = 1'b1;
         bus.instr_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (halted !== 1'b1 || bus.mem_req !== 1'b0 || PI !== 1'b0 || PL !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold halted %b req %b PI %b PL %b want 1 0 0 0",
                     halted, bus.mem_req, PI, PL);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_clear got %b want 0", halted);
      end
      reset_dut(8'h30);
      run_instr(8'h05, 1'b0, 0, 0);
   endtask

   task automatic test_abort();
      bit got;
      reset_dut(8'h40);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = (bus.mem_req === 1'b1);
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL abort_req mem_req never rose");
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 8'h85;
      @(negedge clk);
      bus.mem_ready   = 1'b0;
      bus.instr_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.instr_valid, bus.mem_req, PI, PL} !== 4'b0 || bus.instr_out !== 8'h00) begin
         errors++;
         $display("FAIL abort_now valid/req/PI/PL %b instr %h want 0000 00",
                  {bus.instr_valid, bus.mem_req, PI, PL}, bus.instr_out);
      end
      @(negedge clk);
      bus.instr_ready = 1'b0;
      rst_n  = 1'b1;
      exp_pc = 8'h40;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (PI !== 1'b0 || PL !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet PI %b PL %b want 0 0", PI, PL);
         end
      end
      run_instr(8'h01, 1'b0, 0, 0);
   endtask

   task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
      bit got;
      reset_dut(8'h20);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = (bus.mem_req === 1'b1);
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL to_req mem_req never rose");
      end
      for (int i = 0; i < 15; i++) begin
         checks++;
         if (bus.mem_req !== 1'b1 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL to_wait cycle %0d req %b err %b want 1 0", i, bus.mem_req, fetch_err);
         end
         @(negedge clk);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (fetch_err !== 1'b1 || bus.mem_req !== 1'b0 || PI !== 1'b0 || PL !== 1'b0) begin
            errors++;
            $display("FAIL to_err err %b req %b PI %b PL %b want 1 0 0 0",
                     fetch_err, bus.mem_req, PI, PL);
         end
         bus.mem_ready = 1'b1;
         @(negedge clk);
      end
      reset_dut(8'h20);
      run_instr(8'h05, 1'b0, 14, 0);
      checks++;
      if (fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL to_edge err %b want 0", fetch_err);
      end
      run_instr(8'h06, 1'b0, 0, 0);
`else
      reset_dut(8'h20);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (bus.mem_req !== 1'b1 || fetch_err !== 1'b0) begin
               errors++;
               $display("FAIL no_to cycle %0d req %b err %b want 1 0", i, bus.mem_req, fetch_err);
            end
         end
      end
      run_instr(8'h05, 1'b0, 0, 0);
`endif
   endtask

   initial begin
      test_reset();
      test_normal();
      test_branch();
      test_cond();
      test_wrap();
      test_hold();
      test_halt();
      test_abort();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
